// File: rtl/ws2811_frame_ctrl.sv
// WS2811 frame sequencer: streams num_leds pixel words from RAM to the serializer, then holds the latch gap.
// Optional macro WS2811_AUTOREFRESH_EN adds refresh_en for back-to-back frame repetition.
module ws2811_frame_ctrl #(
   parameter int ADDR_W       = 6,
   parameter int LATCH_CYCLES = 3000,
   parameter int LCNT_W       = 12
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   num_leds,
`ifdef WS2811_AUTOREFRESH_EN
   input  logic              refresh_en,
`endif
   output logic [ADDR_W-1:0] pix_addr,
   output logic              pix_rd,
   input  logic [23:0]       pix_data,
   output logic [23:0]       ser_data,
   output logic              ser_send,
   input  logic              ser_word_sent,
   output logic              busy,
   output logic              frame_done,
   output logic [2:0]        db_estado
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      RDWAIT = 3'd2,
      SEND   = 3'd3,
      WAITW  = 3'd4,
      LATCH  = 3'd5,
      DONE   = 3'd6
   } state_t;

   localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] MAX_N = ONE << ADDR_W;
   localparam logic [LCNT_W-1:0] LATCH_LAST = LCNT_W'(LATCH_CYCLES - 1);

   state_t              state_reg, state_next;
   logic [ADDR_W:0]     idx_reg;
   logic [ADDR_W:0]     n_reg;
   logic [LCNT_W-1:0]   lcnt_reg;
   logic [23:0]         data_reg;

   logic [ADDR_W:0]     n_clamped;
   logic                last_word;
   logic                latch_end;

   assign n_clamped = (num_leds > MAX_N) ? MAX_N : num_leds;
   // Full-width compare so a 2**ADDR_W frame ends at the top address without wrapping
   assign last_word = (idx_reg == (n_reg - ONE));
   assign latch_end = (lcnt_reg == LATCH_LAST);

   assign pix_addr  = idx_reg[ADDR_W-1:0];
   assign ser_data  = data_reg;
   assign db_estado = state_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pix_rd     = 1'b0;
      ser_send   = 1'b0;
      frame_done = 1'b0;
      busy       = (state_reg != IDLE);
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = (n_clamped == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            pix_rd     = 1'b1;
            state_next = RDWAIT;
         end
         RDWAIT: begin
            state_next = SEND;
         end
         SEND: begin
            ser_send   = 1'b1;
            state_next = WAITW;
         end
         WAITW: begin
            if (ser_word_sent) begin
               state_next = last_word ? LATCH : FETCH;
            end
         end
         LATCH: begin
            if (latch_end) begin
               state_next = DONE;
            end
         end
         DONE: begin
            frame_done = 1'b1;
            state_next = IDLE;
`ifdef WS2811_AUTOREFRESH_EN
            // An empty frame has nothing to repeat; fetching with n=0 would run away through the RAM
            if (refresh_en && (n_reg != '0)) begin
               state_next = FETCH;
            end
`endif
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx_reg  <= '0;
         n_reg    <= '0;
         lcnt_reg <= '0;
         data_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  idx_reg <= '0;
                  n_reg   <= n_clamped;
               end
            end
            RDWAIT: begin
               data_reg <= pix_data;
            end
            WAITW: begin
               lcnt_reg <= '0;
               if (ser_word_sent && !last_word) begin
                  idx_reg <= idx_reg + ONE;
               end
            end
            LATCH: begin
               lcnt_reg <= lcnt_reg + LCNT_W'(1);
            end
            DONE: begin
               idx_reg <= '0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ws2811_frame_ctrl.sv
// Directed bench for ws2811_frame_ctrl: RAM and serializer models, event log, timing/ordering checks.
// Build with WS2811_AUTOREFRESH_EN defined to also exercise frame repetition.
module tb_ws2811_frame_ctrl;
   localparam int ADDR_W       = 6;
   localparam int LATCH_CYCLES = 3000;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              refresh_en = 1'b0;
   logic [ADDR_W:0]   num_leds = '0;
   logic [ADDR_W-1:0] pix_addr;
   logic              pix_rd;
   logic [23:0]       pix_data = '0;
   logic [23:0]       ser_data;
   logic              ser_send;
   logic              ser_word_sent = 1'b0;
   logic              busy;
   logic              frame_done;
   logic [2:0]        db_estado;

   ws2811_frame_ctrl #(
      .ADDR_W(ADDR_W),
      .LATCH_CYCLES(LATCH_CYCLES),
      .LCNT_W(12)
   ) dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .num_leds(num_leds),
`ifdef WS2811_AUTOREFRESH_EN
      .refresh_en(refresh_en),
`endif
      .pix_addr(pix_addr),
      .pix_rd(pix_rd),
      .pix_data(pix_data),
      .ser_data(ser_data),
      .ser_send(ser_send),
      .ser_word_sent(ser_word_sent),
      .busy(busy),
      .frame_done(frame_done),
      .db_estado(db_estado)
   );

   initial forever #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic [23:0] ram [0:63];
   always @(posedge clock) if (pix_rd) pix_data <= ram[pix_addr];

   int send_cyc[$];
   int sent_words[$];
   int ack_cyc[$];
   int addr_seen[$];
   int done_cyc[$];
   int busy_cnt = 0;
   int overlap = 0;
   int unstable = 0;
   int ack_cnt = 0;
   int start_cyc = 0;
   bit force_ack = 1'b0;
   logic [23:0] sent_hold = '0;

   int n_checks = 0;
   int n_pass = 0;

   // Serializer model: acknowledges each word 10 cycles after its send pulse
   initial forever begin
      @(negedge clock);
      ser_word_sent = 1'b0;
      if (reset) begin
         ack_cnt = 0;
      end else begin
         if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) begin
               ser_word_sent = 1'b1;
               ack_cyc.push_back(cyc);
               if (ser_data !== sent_hold) unstable++;
            end
         end
         if (force_ack) begin
            ser_word_sent = 1'b1;
            force_ack = 1'b0;
         end
         if (ser_send) begin
            ack_cnt = 10;
            sent_hold = ser_data;
         end
      end
   end

   initial forever begin
      @(negedge clock);
      if (!reset) begin
         if (ser_send) begin
            send_cyc.push_back(cyc);
            sent_words.push_back(int'(ser_data));
         end
         if (pix_rd) addr_seen.push_back(int'(pix_addr));
         if (frame_done) done_cyc.push_back(cyc);
         if (busy) busy_cnt++;
         if (frame_done && ser_send) overlap++;
         if (pix_rd && db_estado != 3'd1) overlap++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic int qi(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic clear_log();
      send_cyc.delete();
      sent_words.delete();
      ack_cyc.delete();
      addr_seen.delete();
      done_cyc.delete();
      busy_cnt = 0;
      overlap = 0;
      unstable = 0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_start(input int nl);
      num_leds = (ADDR_W+1)'(nl);
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_done(input int ndone, input int budget);
      int t = 0;
      while (done_cyc.size() < ndone && t < budget) begin
         @(negedge clock);
         t++;
      end
      check("done_in_time", 32'(done_cyc.size() >= ndone), 32'd1);
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget);
      int t = 0;
      while (db_estado != s && t < budget) begin
         @(negedge clock);
         t++;
      end
      check("state_reached", 32'(db_estado), 32'(s));
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_state"}, 32'(db_estado), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_pulses"}, 32'({pix_rd, ser_send, frame_done}), 32'd0);
      check({tag, "_addr"}, 32'(pix_addr), 32'd0);
      check({tag, "_data"}, 32'(ser_data), 32'd0);
   endtask

   initial begin
      int errs;
      for (int i = 0; i < 64; i++) ram[i] = {8'(i + 1), 8'hA5, 8'(63 - i)};
      ram[0] = 24'hFF0000;
      ram[1] = 24'h00FF00;
      ram[2] = 24'h0000FF;

      #2 reset = 1'b1;
      #1 check_idle_outputs("reset");
      tick(3);
      reset = 1'b0;
      tick(2);

      // Three-word frame: order, latency, inter-word gap, latch gap
      clear_log();
      pulse_start(3);
      wait_done(1, 4000);
      tick(5);
      check("t1_sends", 32'(sent_words.size()), 32'd3);
      check("t1_word0", 32'(qi(sent_words, 0)), 32'h00FF0000);
      check("t1_word1", 32'(qi(sent_words, 1)), 32'h0000FF00);
      check("t1_word2", 32'(qi(sent_words, 2)), 32'h000000FF);
      check("t1_first_send_lat", 32'(qi(send_cyc, 0) - start_cyc), 32'd3);
      check("t1_word_gap", 32'(qi(send_cyc, 1) - qi(ack_cyc, 0)), 32'd3);
      check("t1_latch_gap", 32'(qi(done_cyc, 0) - qi(ack_cyc, 2)), 32'(LATCH_CYCLES + 1));
      check("t1_reads", 32'(addr_seen.size()), 32'd3);
      check("t1_addr2", 32'(qi(addr_seen, 2)), 32'd2);
      check("t1_done_cnt", 32'(done_cyc.size()), 32'd1);
      check("t1_overlap", 32'(overlap), 32'd0);
      check("t1_stable", 32'(unstable), 32'd0);
      check("t1_idle", 32'(db_estado), 32'd0);
      check("t1_busy_cycles", 32'(busy_cnt), 32'(qi(done_cyc, 0) - start_cyc));
      $display("frame 3 leds: sends=%0d done_at=+%0d", sent_words.size(), qi(done_cyc, 0) - start_cyc);

      // Empty frame: straight to DONE
      clear_log();
      pulse_start(0);
      wait_done(1, 20);
      tick(5);
      check("t2_reads", 32'(addr_seen.size()), 32'd0);
      check("t2_sends", 32'(sent_words.size()), 32'd0);
      check("t2_done_lat", 32'(qi(done_cyc, 0) - start_cyc), 32'd1);
      check("t2_busy_cycles", 32'(busy_cnt), 32'd1);
      $display("frame 0 leds: done_at=+%0d busy=%0d", qi(done_cyc, 0) - start_cyc, busy_cnt);

      // Oversized count clamps to a full 64-word frame
      clear_log();
      pulse_start(100);
      wait_done(1, 5000);
      tick(3);
      check("t3_sends", 32'(sent_words.size()), 32'd64);
      check("t3_reads", 32'(addr_seen.size()), 32'd64);
      errs = 0;
      for (int i = 0; i < 64; i++) begin
         if (qi(addr_seen, i) != i) errs++;
         if (qi(sent_words, i) != int'(ram[i])) errs++;
      end
      check("t3_addr_word_errs", 32'(errs), 32'd0);
      check("t3_done_cnt", 32'(done_cyc.size()), 32'd1);
      $display("frame 100 leds: sends=%0d reads=%0d", sent_words.size(), addr_seen.size());

      // Starts while busy and a stray ack in LATCH are ignored
      clear_log();
      pulse_start(2);
      wait_state(3'd4, 20);
      pulse_start(5);
      wait_state(3'd5, 100);
      pulse_start(7);
      force_ack = 1'b1;
      wait_done(1, 4000);
      tick(10);
      check("t4_sends", 32'(sent_words.size()), 32'd2);
      check("t4_done_cnt", 32'(done_cyc.size()), 32'd1);
      check("t4_latch_gap", 32'(qi(done_cyc, 0) - qi(ack_cyc, 1)), 32'(LATCH_CYCLES + 1));
      check("t4_idle", 32'(db_estado), 32'd0);
      $display("busy starts: sends=%0d dones=%0d", sent_words.size(), done_cyc.size());

      // Reset during WAITW of the second word, then a clean frame
      clear_log();
      pulse_start(3);
      begin
         int t = 0;
         while (send_cyc.size() < 2 && t < 100) begin
            @(negedge clock);
            t++;
         end
      end
      tick(1);
      check("t5_in_waitw", 32'(db_estado), 32'd4);
      #2 reset = 1'b1;
      #1 check_idle_outputs("t5_reset");
      @(negedge clock);
      reset = 1'b0;
      clear_log();
      tick(1);
      pulse_start(3);
      wait_done(1, 4000);
      tick(3);
      check("t5_sends", 32'(sent_words.size()), 32'd3);
      errs = 0;
      for (int i = 0; i < 3; i++) begin
         if (qi(addr_seen, i) != i) errs++;
         if (qi(sent_words, i) != int'(ram[i])) errs++;
      end
      check("t5_addr_word_errs", 32'(errs), 32'd0);
      $display("after reset: sends=%0d first_addr=%0d", sent_words.size(), qi(addr_seen, 0));

`ifdef WS2811_AUTOREFRESH_EN
      // Continuous refresh, then drop refresh_en and finish the current frame
      clear_log();
      refresh_en = 1'b1;
      pulse_start(2);
      wait_done(2, 7000);
      refresh_en = 1'b0;
      wait_done(3, 4000);
      tick(10);
      check("t6_period1", 32'(qi(done_cyc, 1) - qi(done_cyc, 0)), 32'(LATCH_CYCLES + 27));
      check("t6_period2", 32'(qi(done_cyc, 2) - qi(done_cyc, 1)), 32'(LATCH_CYCLES + 27));
      check("t6_sends", 32'(sent_words.size()), 32'd6);
      check("t6_busy_cycles", 32'(busy_cnt), 32'(qi(done_cyc, 2) - start_cyc));
      check("t6_done_cnt", 32'(done_cyc.size()), 32'd3);
      check("t6_idle", 32'(db_estado), 32'd0);
      $display("refresh: dones=%0d sends=%0d", done_cyc.size(), sent_words.size());
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
